// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the instruction fetch stage and the controller:
// pc_src encodings, fetch FSM state encoding and the reset NOP.
package fetch_unit_pkg;

    localparam logic [1:0] PC_SRC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
    localparam logic [1:0] PC_SRC_JALR   = 2'b10;
    localparam logic [1:0] PC_SRC_RSVD   = 2'b11;

    // addi x0, x0, 0
    localparam logic [31:0] INSTR_NOP = 32'h00000013;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReq   = 3'd1,
        StWait  = 3'd2,
        StValid = 3'd3,
        StErr   = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/next_pc_gen.sv
// Next-PC computation for the fetch stage: pc+4, pc+imm and jalr target mux.
// With FETCH_MISALIGN_EN defined the raw target is passed through together with a
// misalignment flag; otherwise the low two bits of the target are silently cleared.
module next_pc_gen
    import fetch_unit_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] pc,
    input  logic [1:0]      pc_src,
    input  logic [XLEN-1:0] imm_ext,
    input  logic [XLEN-1:0] alu_result,
    output logic [XLEN-1:0] pc_plus4,
    output logic [XLEN-1:0] next_pc
`ifdef FETCH_MISALIGN_EN
    ,
    output logic            misalign
`endif
);

    localparam logic [XLEN-1:0] FOUR      = {{(XLEN-3){1'b0}}, 3'b100};
    localparam logic [XLEN-1:0] JALR_MASK = {{(XLEN-1){1'b1}}, 1'b0};

    logic [XLEN-1:0] target;

    assign pc_plus4 = pc + FOUR;

    // Target select; reserved encoding behaves as sequential fetch
    always_comb begin
        target = pc_plus4;
        case (pc_src)
            PC_SRC_PLUS4:  target = pc_plus4;
            PC_SRC_BRANCH: target = pc + imm_ext;
            PC_SRC_JALR:   target = alu_result & JALR_MASK;
            PC_SRC_RSVD:   target = pc_plus4;
            default:       target = pc_plus4;
        endcase
    end

`ifdef FETCH_MISALIGN_EN
    assign next_pc  = target;
    assign misalign = |target[1:0];
`else
    localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};
    assign next_pc = target & ALIGN_MASK;
`endif

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: holds the PC, fetches over a req/gnt/rvalid handshake and
// presents the word to decode with valid/stall flow control. A response timeout parks
// the unit in a sticky error state until reset.
// Optional feature macro: FETCH_MISALIGN_EN (trap on misaligned next-PC target).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int unsigned     MAX_WAIT = 15
) (
    input  logic            i_clk,
    input  logic            i_rst,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_gnt,
    input  logic            i_imem_rvalid,
    input  logic [31:0]     i_imem_rdata,
    output logic [31:0]     o_instr,
    output logic            o_instr_valid,
    input  logic            i_stall,
    input  logic [1:0]      i_pc_src,
    input  logic [XLEN-1:0] i_imm_ext,
    input  logic [XLEN-1:0] i_alu_result,
    output logic [XLEN-1:0] o_pc,
    output logic [XLEN-1:0] o_pc_plus4,
    output logic            o_bus_err,
    output logic            o_misalign
);

    // Last WAIT cycle count value before declaring a timeout
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    fetch_state_e    state_q;
    logic [7:0]      wait_cnt_q;
    logic [XLEN-1:0] pc_q;
    logic [31:0]     instr_q;
    logic            instr_valid_q;
    logic            req_q;
    logic            bus_err_q;
    logic [XLEN-1:0] next_pc;
    logic            consume;

    assign consume = instr_valid_q & ~i_stall;

`ifdef FETCH_MISALIGN_EN
    logic next_misalign;
    logic misalign_q;
`endif

    next_pc_gen #(
        .XLEN (XLEN)
    ) u_next_pc_gen (
        .pc         (pc_q),
        .pc_src     (i_pc_src),
        .imm_ext    (i_imm_ext),
        .alu_result (i_alu_result),
        .pc_plus4   (o_pc_plus4),
        .next_pc    (next_pc)
`ifdef FETCH_MISALIGN_EN
        ,
        .misalign   (next_misalign)
`endif
    );

    // Fetch FSM with registered request, PC, instruction and status outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q       <= StIdle;
            wait_cnt_q    <= '0;
            pc_q          <= RESET_PC;
            instr_q       <= INSTR_NOP;
            instr_valid_q <= 1'b0;
            req_q         <= 1'b0;
            bus_err_q     <= 1'b0;
`ifdef FETCH_MISALIGN_EN
            misalign_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                StIdle: begin
                    state_q <= StReq;
                    req_q   <= 1'b1;
                end
                StReq: begin
                    if (i_imem_gnt) begin
                        req_q      <= 1'b0;
                        wait_cnt_q <= '0;
                        if (i_imem_rvalid) begin
                            instr_q       <= i_imem_rdata;
                            instr_valid_q <= 1'b1;
                            state_q       <= StValid;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (i_imem_rvalid) begin
                        instr_q       <= i_imem_rdata;
                        instr_valid_q <= 1'b1;
                        wait_cnt_q    <= '0;
                        state_q       <= StValid;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        bus_err_q <= 1'b1;
                        state_q   <= StErr;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                StValid: begin
                    if (consume) begin
                        instr_valid_q <= 1'b0;
                        pc_q          <= next_pc;
`ifdef FETCH_MISALIGN_EN
                        if (next_misalign) begin
                            misalign_q <= 1'b1;
                            state_q    <= StErr;
                        end else begin
                            req_q   <= 1'b1;
                            state_q <= StReq;
                        end
`else
                        req_q   <= 1'b1;
                        state_q <= StReq;
`endif
                    end
                end
                StErr: begin
                    req_q         <= 1'b0;
                    instr_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_imem_req    = req_q;
    assign o_imem_addr   = pc_q;
    assign o_pc          = pc_q;
    assign o_instr       = instr_q;
    assign o_instr_valid = instr_valid_q;
    assign o_bus_err     = bus_err_q;
`ifdef FETCH_MISALIGN_EN
    assign o_misalign    = misalign_q;
`else
    assign o_misalign    = 1'b0;
`endif

endmodule
